// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: game sequencer for the snake datapath.
//
// Takes a frame tick from the falling edge of v_disp, which is the entry to vertical
// blanking. Every FRAMES_PER_STEP frames it moves the head one grid cell in the latched
// direction. It checks for wall, body and food events and keeps track of length and score.
// It pulses step_pulse so that the body-shift logic and the renderer update during blanking.
//
// Optional feature: define WRAP_WALLS_EN to make the grid edges wrap around. With this
// feature enabled, only body_hit ends the game.
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-high reset
//   v_disp                   vertical display-active (1 = active, 0 = blanking)
//   start                    level input; starts a game from IDLE, returns from OVER to IDLE
//   btn_up/down/left/right   synchronised direction buttons (level)
//   food_x, food_y           food cell
//   body_hit                 body-collision flag, sampled in the STEP cycle
//   head_x, head_y           head cell
//   dir                      committed direction: 0 right, 1 left, 2 up, 3 down
//   length, score            snake length (saturates at MAX_LEN), food eaten (saturates at 255)
//   state                    0 IDLE, 1 RUN, 2 STEP, 3 OVER
//   step_pulse, food_eaten   one-cycle registered pulses after a successful move
//   game_over                high while in OVER
module snake_step_ctrl #(
    parameter int GRID_W          = 40,
    parameter int GRID_H          = 30,
    parameter int FRAMES_PER_STEP = 8,
    parameter int INIT_LEN        = 3,
    parameter int MAX_LEN         = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       v_disp,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [5:0] food_x,
    input  logic [4:0] food_y,
    input  logic       body_hit,
    output logic [5:0] head_x,
    output logic [4:0] head_y,
    output logic [1:0] dir,
    output logic [6:0] length,
    output logic [7:0] score,
    output logic [1:0] state,
    output logic       step_pulse,
    output logic       food_eaten,
    output logic       game_over
);

    localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [5:0] InitX = 6'(GRID_W / 2);
    localparam logic [4:0] InitY = 5'(GRID_H / 2);
    localparam logic [5:0] MaxX  = 6'(GRID_W - 1);
    localparam logic [4:0] MaxY  = 5'(GRID_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       head_x_q, head_x_d;
    logic [4:0]       head_y_q, head_y_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       pend_q, pend_d;
    logic [6:0]       length_q, length_d;
    logic [7:0]       score_q, score_d;
    logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
    logic             v_disp_q;
    logic             step_q, step_d;
    logic             food_q, food_d;

    logic             frame_tick;
    logic             any_btn;
    logic [1:0]       cand;
    logic [5:0]       next_x;
    logic [4:0]       next_y;
    logic             at_wall;
    logic             blocked;

    assign frame_tick = v_disp_q & ~v_disp;

    // Button priority is up > down > left > right.
    always_comb begin
        any_btn = btn_up | btn_down | btn_left | btn_right;
        if (btn_up)          cand = 2'd2;
        else if (btn_down)   cand = 2'd3;
        else if (btn_left)   cand = 2'd1;
        else                 cand = 2'd0;
    end

    // Compute the next head cell from the pending direction. The edge case always wraps,
    // and at_wall tells whether the move actually left the grid.
    always_comb begin
        next_x  = head_x_q;
        next_y  = head_y_q;
        at_wall = 1'b0;
        unique case (pend_q)
            2'd0: begin
                at_wall = (head_x_q == MaxX);
                next_x  = at_wall ? 6'd0 : head_x_q + 6'd1;
            end
            2'd1: begin
                at_wall = (head_x_q == 6'd0);
                next_x  = at_wall ? MaxX : head_x_q - 6'd1;
            end
            2'd2: begin
                at_wall = (head_y_q == 5'd0);
                next_y  = at_wall ? MaxY : head_y_q - 5'd1;
            end
            default: begin
                at_wall = (head_y_q == MaxY);
                next_y  = at_wall ? 5'd0 : head_y_q + 5'd1;
            end
        endcase
    end

`ifdef WRAP_WALLS_EN
    assign blocked = body_hit;
`else
    assign blocked = body_hit | at_wall;
`endif

    always_comb begin
        state_d     = state_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        length_d    = length_q;
        score_d     = score_q;
        frame_cnt_d = frame_cnt_q;
        step_d      = 1'b0;
        food_d      = 1'b0;

        // A reversal is the committed direction with bit 0 flipped.
        if ((state_q == IDLE || state_q == RUN) && any_btn && (cand != (dir_q ^ 2'd1))) begin
            pend_d = cand;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    frame_cnt_d = '0;
                end
            end
            RUN: begin
                if (frame_tick) begin
                    if (frame_cnt_q == FCW'(FRAMES_PER_STEP - 1)) begin
                        frame_cnt_d = '0;
                        state_d     = STEP;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                    end
                end
            end
            STEP: begin
                dir_d = pend_q;
                if (blocked) begin
                    state_d = OVER;
                end else begin
                    state_d  = RUN;
                    head_x_d = next_x;
                    head_y_d = next_y;
                    step_d   = 1'b1;
                    if (next_x == food_x && next_y == food_y) begin
                        food_d = 1'b1;
                        if (length_q != 7'(MAX_LEN)) length_d = length_q + 7'd1;
                        if (score_q != 8'hFF)        score_d  = score_q + 8'd1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d     = IDLE;
                    head_x_d    = InitX;
                    head_y_d    = InitY;
                    dir_d       = 2'd0;
                    pend_d      = 2'd0;
                    length_d    = 7'(INIT_LEN);
                    score_d     = 8'd0;
                    frame_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            head_x_q    <= InitX;
            head_y_q    <= InitY;
            dir_q       <= 2'd0;
            pend_q      <= 2'd0;
            length_q    <= 7'(INIT_LEN);
            score_q     <= 8'd0;
            frame_cnt_q <= '0;
            v_disp_q    <= 1'b1;
            step_q      <= 1'b0;
            food_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            length_q    <= length_d;
            score_q     <= score_d;
            frame_cnt_q <= frame_cnt_d;
            v_disp_q    <= v_disp;
            step_q      <= step_d;
            food_q      <= food_d;
        end
    end

    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign dir        = dir_q;
    assign length     = length_q;
    assign score      = score_q;
    assign state      = state_q;
    assign step_pulse = step_q;
    assign food_eaten = food_q;
    assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl. Inputs change on the falling clock edge, and outputs
// are sampled on the falling clock edge.
module tb_snake_step_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       v_disp;
    logic       start;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic [5:0] food_x;
    logic [4:0] food_y;
    logic       body_hit;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [1:0] dir;
    logic [6:0] length;
    logic [7:0] score;
    logic [1:0] state;
    logic       step_pulse;
    logic       food_eaten;
    logic       game_over;

    int n_vec = 0;
    int n_err = 0;

    snake_step_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .v_disp     (v_disp),
        .start      (start),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .food_x     (food_x),
        .food_y     (food_y),
        .body_hit   (body_hit),
        .head_x     (head_x),
        .head_y     (head_y),
        .dir        (dir),
        .length     (length),
        .score      (score),
        .state      (state),
        .step_pulse (step_pulse),
        .food_eaten (food_eaten),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One v_disp falling edge: low for one cycle, then high again.
    task automatic frame();
        @(negedge clk) v_disp = 1'b0;
        @(negedge clk) v_disp = 1'b1;
    endtask

    // Eight frames. The task returns at a falling edge while the DUT sits in STEP.
    task automatic to_step(input string tag);
        for (int i = 0; i < 8; i++) frame();
        check_val(tag, state, 2);
    endtask

    // Hold one button for one cycle: 0 right, 1 left, 2 up, 3 down.
    task automatic press(input int b);
        @(negedge clk);
        btn_right = (b == 0);
        btn_left  = (b == 1);
        btn_up    = (b == 2);
        btn_down  = (b == 3);
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    int exp_hx;

    initial begin
        rst = 1'b1; v_disp = 1'b1; start = 1'b0; body_hit = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        food_x = 6'd0; food_y = 5'd0;

        // Reset state
        @(negedge clk);
        check_val("rst_state", state, 0);
        check_val("rst_hx", head_x, 20);
        check_val("rst_hy", head_y, 15);
        check_val("rst_len", length, 3);
        check_val("rst_score", score, 0);
        check_val("rst_dir", dir, 0);
        check_val("rst_over", game_over, 0);
        rst = 1'b0;

        // Frames in IDLE must not cause a move.
        frame();
        check_val("idle_hold", state, 0);

        // Test 1: start, then eight frames give one step to the right.
        pulse_start();
        check_val("t1_run", state, 1);
        for (int i = 0; i < 7; i++) frame();
        check_val("t1_not_yet", state, 1);
        frame();
        check_val("t1_step_state", state, 2);
        check_val("t1_no_early_pulse", step_pulse, 0);
        @(negedge clk);
        check_val("t1_pulse", step_pulse, 1);
        check_val("t1_hx", head_x, 21);
        check_val("t1_hy", head_y, 15);
        check_val("t1_dir", dir, 0);
        check_val("t1_back_run", state, 1);
        @(negedge clk);
        check_val("t1_pulse_1cyc", step_pulse, 0);

        // Test 2: left is a reversal and is ignored; up is taken.
        press(1);
        press(2);
        to_step("t2_step");
        @(negedge clk);
        check_val("t2_hx", head_x, 21);
        check_val("t2_hy", head_y, 14);
        check_val("t2_dir", dir, 2);

        // Steer to (38,15) heading right.
        press(0);
        to_step("nav_a");
        @(negedge clk);
        press(3);
        to_step("nav_b");
        @(negedge clk);
        check_val("nav_hx", head_x, 22);
        check_val("nav_hy", head_y, 15);
        check_val("nav_dir", dir, 3);
        press(0);
        for (int i = 0; i < 16; i++) begin
            to_step("nav_walk");
            @(negedge clk);
        end
        check_val("nav_hx38", head_x, 38);

        // Test 3: eat food at the right edge, then move into the wall.
        food_x = 6'd39; food_y = 5'd15;
        to_step("t3_step1");
        @(negedge clk);
        check_val("t3_pulse", step_pulse, 1);
        check_val("t3_eaten", food_eaten, 1);
        check_val("t3_len", length, 4);
        check_val("t3_score", score, 1);
        check_val("t3_hx", head_x, 39);
        @(negedge clk);
        check_val("t3_eaten_1cyc", food_eaten, 0);
        to_step("t3_step2");
        @(negedge clk);
`ifdef WRAP_WALLS_EN
        // Test 4: wrap to column 0 and keep running.
        check_val("t4_state", state, 1);
        check_val("t4_hx", head_x, 0);
        check_val("t4_hy", head_y, 15);
        check_val("t4_pulse", step_pulse, 1);
        exp_hx = 0;
`else
        check_val("t3_over_state", state, 3);
        check_val("t3_game_over", game_over, 1);
        check_val("t3_no_pulse", step_pulse, 0);
        check_val("t3_hold_hx", head_x, 39);
        check_val("t3_hold_len", length, 4);
        @(negedge clk);
        check_val("over_ignores_frames", state, 3);
        pulse_start();
        check_val("reinit_idle", state, 0);
        pulse_start();
        check_val("restart_run", state, 1);
        exp_hx = 20;
`endif

        // Test 5: body_hit during STEP ends the game with no move.
        to_step("t5_step");
        body_hit = 1'b1;
        @(negedge clk);
        body_hit = 1'b0;
        check_val("t5_state", state, 3);
        check_val("t5_no_pulse", step_pulse, 0);
        check_val("t5_hx", head_x, exp_hx);
        check_val("t5_over", game_over, 1);
        // Hold start: OVER -> IDLE -> RUN on consecutive cycles.
        start = 1'b1;
        @(negedge clk);
        check_val("t5_idle", state, 0);
        check_val("t5_hx_init", head_x, 20);
        check_val("t5_hy_init", head_y, 15);
        check_val("t5_len_init", length, 3);
        check_val("t5_score_init", score, 0);
        check_val("t5_over_clr", game_over, 0);
        @(negedge clk);
        check_val("t5_run", state, 1);
        @(negedge clk);
        start = 1'b0;
        check_val("t5_run_ignores_start", state, 1);

        // Test 6: asynchronous reset in the STEP cycle.
        to_step("t6_step");
        rst = 1'b1;
        #1;
        check_val("t6_async_state", state, 0);
        check_val("t6_async_pulse", step_pulse, 0);
        check_val("t6_async_hx", head_x, 20);
        @(negedge clk);
        check_val("t6_hold_hx", head_x, 20);
        check_val("t6_hold_pulse", step_pulse, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("t6_idle", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
